// File: rtl/rect_plot_engine.sv
// Rectangle fill engine: accepts origin/size/colour commands on a valid/ready port
// and emits one framebuffer pixel per cycle in raster order, optionally frame-paced.
module rect_plot_engine #(
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int CW        = 3,
  parameter int TIMER_MAX = 833333,
  parameter int TW        = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_color,
  input  logic          cmd_wait,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] color_draw,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic          frame_tick,
  output logic [1:0]    state
);

  // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
  // cmd_ready is high only in IDLE, and the source holds the command until then.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_x0, r_w, r_cx, r_x;
  logic [YW-1:0] r_y0, r_h, r_cy, r_y;
  logic [CW-1:0] r_col, r_color_out;
  logic          r_clip;
  logic [TW-1:0] r_timer;

  logic          w_tick, w_last_col, w_last_row;
  logic [XW-1:0] w_ncx;
  logic [YW-1:0] w_ncy;
  logic [XW:0]   w_sx;
  logic [YW:0]   w_sy;

  assign w_tick     = (r_timer == TW'(TIMER_MAX - 1));
  assign w_last_col = (r_cx == r_w - XW'(1));
  assign w_last_row = (r_cy == r_h - YW'(1));

  // Next raster position and its screen address; the extra bit flags a clip.
  always_comb begin
    w_ncx = w_last_col ? '0 : r_cx + XW'(1);
    w_ncy = w_last_col ? r_cy + YW'(1) : r_cy;
    w_sx  = {1'b0, r_x0} + {1'b0, w_ncx};
    w_sy  = {1'b0, r_y0} + {1'b0, w_ncy};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_col       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_color_out <= '0;
      r_clip      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_x0  <= cmd_x;
            r_y0  <= cmd_y;
            r_w   <= cmd_w;
            r_h   <= cmd_h;
            r_col <= cmd_color;
            r_cx  <= '0;
            r_cy  <= '0;
            if (cmd_w == '0 || cmd_h == '0) begin
              r_state <= S_DONE;
            end else if (cmd_wait) begin
              r_state <= S_WAIT;
            end else begin
              // First pixel is the origin itself, which can never clip.
              r_state     <= S_DRAW;
              r_x         <= cmd_x;
              r_y         <= cmd_y;
              r_color_out <= cmd_color;
              r_clip      <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_tick) begin
            r_state     <= S_DRAW;
            r_x         <= r_x0;
            r_y         <= r_y0;
            r_color_out <= r_col;
            r_clip      <= 1'b0;
          end
        end
        S_DRAW: begin
          if (w_last_col && w_last_row) begin
            r_state <= S_DONE;
          end else begin
            r_cx   <= w_ncx;
            r_cy   <= w_ncy;
            r_x    <= w_sx[XW-1:0];
            r_y    <= w_sy[YW-1:0];
            r_clip <= w_sx[XW] | w_sy[YW];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign color_draw = r_color_out;
  assign plot       = (r_state == S_DRAW) && !r_clip;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign cmd_ready  = (r_state == S_IDLE);
  assign frame_tick = w_tick;
  assign state      = r_state;

endmodule

// File: tb/tb_rect_plot_engine.sv
// Bench for rect_plot_engine: table vectors, frame-paced and reset corner cases,
// and random commands scored pixel by pixel against a raster model.
module tb_rect_plot_engine;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int TM = 16;
  localparam int TW = 5;
  localparam int PW = XW + YW + CW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x = '0;
  logic [YW-1:0] cmd_y = '0;
  logic [XW-1:0] cmd_w = '0;
  logic [YW-1:0] cmd_h = '0;
  logic [CW-1:0] cmd_color = '0;
  logic          cmd_wait = 1'b0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] color_draw;
  logic          plot, busy, done, frame_tick;
  logic [1:0]    state;

  rect_plot_engine #(.XW(XW), .YW(YW), .CW(CW), .TIMER_MAX(TM), .TW(TW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_wait(cmd_wait), .x(x), .y(y),
    .color_draw(color_draw), .plot(plot), .busy(busy), .done(done),
    .frame_tick(frame_tick), .state(state)
  );

  // ---------------- clock / reset-aware cycle count ----------------
  always #5 clk = ~clk;

  int tb_cnt;  // rising edges since reset released; timer model = tb_cnt % TM
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= tb_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) chk("frame_tick", 32'(frame_tick), 32'((tb_cnt % TM) == TM - 1));
  end

  // ---------------- driver ----------------
  // Caller is at a negedge. Runs one command to completion and checks every cycle.
  task automatic run_cmd(input int cx0, input int cy0, input int w, input int h,
                         input int col, input int wt, input bit junk,
                         output int plots);
    int budget, t, nw, px, py;
    logic [PW-1:0] e;
    plots = 0;
    budget = 0;
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    t = tb_cnt % TM;
    cmd_x = XW'(cx0); cmd_y = YW'(cy0); cmd_w = XW'(w); cmd_h = YW'(h);
    cmd_color = CW'(col); cmd_wait = wt[0]; cmd_valid = 1'b1;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = cx0 + c;
        py = cy0 + r;
        exp_q.push_back({XW'(px), YW'(py), CW'(col), 1'((px < 256) && (py < 128))});
      end
    end
    @(posedge clk);
    #1;
    if (junk) begin
      cmd_x = XW'($urandom); cmd_y = YW'($urandom); cmd_w = XW'($urandom_range(1, 9));
      cmd_h = YW'($urandom_range(1, 9)); cmd_color = CW'($urandom); cmd_wait = 1'b0;
    end else begin
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    if (w != 0 && h != 0 && wt != 0) begin
      nw = (t == TM - 1) ? TM : TM - 1 - t;
      for (int i = 0; i < nw; i++) begin
        chk("wait_state", {29'd0, state, plot}, {29'd0, 2'd1, 1'b0});
        @(negedge clk);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pixel", {11'd0, state, x, y, color_draw, plot}, {11'd0, 2'd2, e});
      plots += int'(plot);
      @(negedge clk);
    end
    chk("done_pulse", {29'd0, state, done}, {29'd0, 2'd3, 1'b1});
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {29'd0, cmd_ready, done, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
  endtask

  typedef struct {
    int x, y, w, h, col, wt, exp_plots;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int plots, budget, t0, exp_n, px, py;
    vecs[0] = '{10, 20, 3, 2, 5, 0, 6};
    vecs[1] = '{0, 0, 0, 5, 1, 0, 0};
    vecs[2] = '{254, 0, 4, 1, 2, 0, 2};
    vecs[3] = '{5, 126, 2, 3, 7, 0, 4};
    vecs[4] = '{250, 120, 3, 0, 3, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 6, 1, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_outs", {21'd0, plot, done, busy, x}, 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors; the first one also holds a junk command on the port while busy
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].col, vecs[i].wt,
              (i == 0), plots);
      chk("vec_plots", 32'(plots), 32'(vecs[i].exp_plots));
    end

    // Frame tick period
    budget = 0;
    while (!frame_tick && budget < 40) begin @(negedge clk); budget++; end
    chk("tick_seen", 32'(frame_tick), 32'd1);
    t0 = tb_cnt;
    @(negedge clk);
    budget = 0;
    while (!frame_tick && budget < 40) begin @(negedge clk); budget++; end
    chk("tick_period", 32'(tb_cnt - t0), 32'(TM));

    // Frame-paced command accepted at timer count 3
    budget = 0;
    while ((tb_cnt % TM) != 3 && budget < 40) begin @(negedge clk); budget++; end
    run_cmd(30, 40, 2, 2, 4, 1, 1'b0, plots);
    chk("wait_plots", 32'(plots), 32'd4);

    // Reset mid-DRAW of an 8x8 rectangle
    cmd_x = 8'd40; cmd_y = 7'd30; cmd_w = 8'd8; cmd_h = 7'd8; cmd_color = 3'd2;
    cmd_wait = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_draw_plot", 32'(plot), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_outs", {28'd0, state, plot, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", {29'd0, cmd_ready, busy, done}, {29'd0, 1'b1, 1'b0, 1'b0});
    run_cmd(100, 50, 2, 2, 6, 0, 1'b0, plots);
    chk("post_reset_plots", 32'(plots), 32'd4);

    // Random commands
    for (int i = 0; i < 30; i++) begin
      int rx, ry, rw, rh, rc, rwt;
      rx = (i % 3 == 0) ? $urandom_range(248, 255) : $urandom_range(0, 255);
      ry = (i % 4 == 0) ? $urandom_range(122, 127) : $urandom_range(0, 127);
      rw = $urandom_range(0, 6);
      rh = $urandom_range(0, 5);
      rc = $urandom_range(0, 7);
      rwt = ($urandom_range(0, 3) == 0) ? 1 : 0;
      exp_n = 0;
      for (int r = 0; r < rh; r++)
        for (int c = 0; c < rw; c++) begin
          px = rx + c;
          py = ry + r;
          if (px < 256 && py < 128) exp_n++;
        end
      run_cmd(rx, ry, rw, rh, rc, rwt, 1'($urandom_range(0, 1)), plots);
      chk("rand_plots", 32'(plots), 32'(exp_n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
